// File: rtl/plot_fb_sink_if.sv
// rtl/plot_fb_sink_if.sv - pixel-plot write bus and raster scan-out bus for plot_fb_sink
interface plot_fb_sink_if #(
   parameter int CW = 3
);
   logic [7:0]    vga_x;
   logic [6:0]    vga_y;
   logic [CW-1:0] vga_colour;
   logic          vga_plot;

   logic          pix_valid;
   logic [7:0]    pix_x;
   logic [6:0]    pix_y;
   logic [CW-1:0] pix_colour;
   logic          pix_last;

   modport master (
      output vga_x, vga_y, vga_colour, vga_plot,
      input  pix_valid, pix_x, pix_y, pix_colour, pix_last
   );

   modport slave (
      input  vga_x, vga_y, vga_colour, vga_plot,
      output pix_valid, pix_x, pix_y, pix_colour, pix_last
   );
endinterface

// File: rtl/plot_fb_sink.sv
// rtl/plot_fb_sink.sv - framebuffer sink for pixel plots with clear sweep and raster read-back
// Optional bounding-box tracking of accepted plots is enabled by defining PLOT_FB_SINK_BBOX_EN.
module plot_fb_sink #(
   parameter int FB_W = 160,
   parameter int FB_H = 120,
   parameter int CW   = 3
) (
   input  logic          clk,
   input  logic          rst,
   plot_fb_sink_if.slave bus,
   input  logic          clear_req,
   input  logic          scan_start,
   output logic          busy,
   output logic [15:0]   plot_count,
   output logic [7:0]    drop_count
`ifdef PLOT_FB_SINK_BBOX_EN
   ,
   output logic          bbox_valid,
   output logic [7:0]    bbox_xmin,
   output logic [7:0]    bbox_xmax,
   output logic [6:0]    bbox_ymin,
   output logic [6:0]    bbox_ymax
`endif
);
   localparam int          NPIX      = FB_W * FB_H;
   localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
   localparam logic [7:0]  W_LIM     = 8'(FB_W);
   localparam logic [6:0]  H_LIM     = 7'(FB_H);

   typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;

   function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
      if (FB_W == 160)
         return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
      else
         return 15'(y * FB_W) + {7'b0, x};
   endfunction

   state_t        state_q, state_d;
   logic [14:0]   clr_addr_q, clr_addr_d;
   logic [7:0]    sx_q, sx_d;
   logic [6:0]    sy_q, sy_d;
   logic          busy_q, busy_d;
   logic          pix_valid_q, pix_valid_d;
   logic          pix_last_q, pix_last_d;
   logic [7:0]    pix_x_q, pix_x_d;
   logic [6:0]    pix_y_q, pix_y_d;
   logic [15:0]   plot_count_q, plot_count_d;
   logic [7:0]    drop_count_q, drop_count_d;

   logic [CW-1:0] mem [NPIX];
   logic [CW-1:0] rd_data_q;

   logic          plot_accept;
   logic          wr_en;
   logic [14:0]   wr_addr;
   logic [CW-1:0] wr_data;
   logic          rd_en;
   logic [14:0]   rd_addr;

   always_comb begin
      plot_accept = bus.vga_plot && (bus.vga_x < W_LIM) && (bus.vga_y < H_LIM)
                    && (state_q != CLEAR);
      // The clear sweep owns the write port; plots are dropped while it runs.
      wr_en   = (state_q == CLEAR) || plot_accept;
      wr_addr = (state_q == CLEAR) ? clr_addr_q : pix_addr(bus.vga_x, bus.vga_y);
      wr_data = (state_q == CLEAR) ? '0 : bus.vga_colour;
      rd_en   = (state_q == SCAN);
      rd_addr = pix_addr(sx_q, sy_q);
   end

   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      sx_d        = sx_q;
      sy_d        = sy_q;
      pix_valid_d = 1'b0;
      pix_last_d  = 1'b0;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end else if (scan_start) begin
               state_d = SCAN;
               sx_d    = '0;
               sy_d    = '0;
            end
         end
         CLEAR: begin
            if (clr_addr_q == LAST_ADDR)
               state_d = IDLE;
            else
               clr_addr_d = clr_addr_q + 15'd1;
         end
         SCAN: begin
            pix_valid_d = 1'b1;
            pix_x_d     = sx_q;
            pix_y_d     = sy_q;
            if (sx_q == W_LIM - 8'd1) begin
               sx_d = '0;
               if (sy_q == H_LIM - 7'd1) begin
                  pix_last_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  sy_d = sy_q + 7'd1;
               end
            end else begin
               sx_d = sx_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // The final scan-out pixel lands one cycle after SCAN has already returned to IDLE.
      busy_d = (state_d != IDLE) || pix_valid_d;

      plot_count_d = plot_count_q;
      if (plot_accept && plot_count_q != 16'hFFFF)
         plot_count_d = plot_count_q + 16'd1;
      drop_count_d = drop_count_q;
      if (bus.vga_plot && !plot_accept && drop_count_q != 8'hFF)
         drop_count_d = drop_count_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         clr_addr_q   <= '0;
         sx_q         <= '0;
         sy_q         <= '0;
         busy_q       <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_last_q   <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         plot_count_q <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         busy_q       <= busy_d;
         pix_valid_q  <= pix_valid_d;
         pix_last_q   <= pix_last_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         plot_count_q <= plot_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Contents survive reset; read-first when a plot hits the address being scanned.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data_q <= mem[rd_addr];
   end

   assign busy           = busy_q;
   assign plot_count     = plot_count_q;
   assign drop_count     = drop_count_q;
   assign bus.pix_valid  = pix_valid_q;
   assign bus.pix_last   = pix_last_q;
   assign bus.pix_x      = pix_x_q;
   assign bus.pix_y      = pix_y_q;
   assign bus.pix_colour = pix_valid_q ? rd_data_q : '0;

`ifdef PLOT_FB_SINK_BBOX_EN
   logic       bbox_valid_q, bbox_valid_d;
   logic [7:0] bbox_xmin_q, bbox_xmin_d, bbox_xmax_q, bbox_xmax_d;
   logic [6:0] bbox_ymin_q, bbox_ymin_d, bbox_ymax_q, bbox_ymax_d;

   always_comb begin
      bbox_valid_d = bbox_valid_q;
      bbox_xmin_d  = bbox_xmin_q;
      bbox_xmax_d  = bbox_xmax_q;
      bbox_ymin_d  = bbox_ymin_q;
      bbox_ymax_d  = bbox_ymax_q;
      if (state_q == IDLE && clear_req) begin
         bbox_valid_d = 1'b0;
         bbox_xmin_d  = 8'hFF;
         bbox_xmax_d  = '0;
         bbox_ymin_d  = 7'h7F;
         bbox_ymax_d  = '0;
      end else if (plot_accept) begin
         bbox_valid_d = 1'b1;
         if (bus.vga_x < bbox_xmin_q) bbox_xmin_d = bus.vga_x;
         if (bus.vga_x > bbox_xmax_q) bbox_xmax_d = bus.vga_x;
         if (bus.vga_y < bbox_ymin_q) bbox_ymin_d = bus.vga_y;
         if (bus.vga_y > bbox_ymax_q) bbox_ymax_d = bus.vga_y;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bbox_valid_q <= 1'b0;
         bbox_xmin_q  <= 8'hFF;
         bbox_xmax_q  <= '0;
         bbox_ymin_q  <= 7'h7F;
         bbox_ymax_q  <= '0;
      end else begin
         bbox_valid_q <= bbox_valid_d;
         bbox_xmin_q  <= bbox_xmin_d;
         bbox_xmax_q  <= bbox_xmax_d;
         bbox_ymin_q  <= bbox_ymin_d;
         bbox_ymax_q  <= bbox_ymax_d;
      end
   end

   assign bbox_valid = bbox_valid_q;
   assign bbox_xmin  = bbox_xmin_q;
   assign bbox_xmax  = bbox_xmax_q;
   assign bbox_ymin  = bbox_ymin_q;
   assign bbox_ymax  = bbox_ymax_q;
`endif
endmodule

// File: tb/tb_plot_fb_sink.sv
// tb/tb_plot_fb_sink.sv - scoreboard bench for plot_fb_sink against a framebuffer array model
module tb_plot_fb_sink;
   localparam int FB_W = 160;
   localparam int FB_H = 120;
   localparam int CW   = 3;
   localparam int NPIX = FB_W * FB_H;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear_req = 1'b0;
   logic        scan_start = 1'b0;
   logic        busy;
   logic [15:0] plot_count;
   logic [7:0]  drop_count;
`ifdef PLOT_FB_SINK_BBOX_EN
   logic        bbox_valid;
   logic [7:0]  bbox_xmin, bbox_xmax;
   logic [6:0]  bbox_ymin, bbox_ymax;
`endif

   plot_fb_sink_if #(.CW(CW)) bus ();

   plot_fb_sink #(.FB_W(FB_W), .FB_H(FB_H), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .clear_req  (clear_req),
      .scan_start (scan_start),
      .busy       (busy),
      .plot_count (plot_count),
      .drop_count (drop_count)
`ifdef PLOT_FB_SINK_BBOX_EN
      ,
      .bbox_valid (bbox_valid),
      .bbox_xmin  (bbox_xmin),
      .bbox_xmax  (bbox_xmax),
      .bbox_ymin  (bbox_ymin),
      .bbox_ymax  (bbox_ymax)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int c;
      bit last;
   } pix_t;

   pix_t sb[$];
   pix_t exp_p;
   int   fb[NPIX];
   int   m_plot, m_drop;
   int   bx0, bx1, by0, by1;
   bit   bv;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   seen_valid, first_v, last_v;
   int   dx[8], dy[8], dc[8];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_bbox_reset();
      bv = 0; bx0 = 255; bx1 = 0; by0 = 127; by1 = 0;
   endtask

   task automatic model_plot(input int x, input int y, input int c, input bit in_clear);
      if (!in_clear && x < FB_W && y < FB_H) begin
         fb[y * FB_W + x] = c;
         if (m_plot < 65535) m_plot++;
         bv = 1;
         if (x < bx0) bx0 = x;
         if (x > bx1) bx1 = x;
         if (y < by0) by0 = y;
         if (y > by1) by1 = y;
      end else if (m_drop < 255) begin
         m_drop++;
      end
   endtask

   task automatic do_plot(input int x, input int y, input int c);
      @(posedge clk); #1;
      bus.vga_x = 8'(x); bus.vga_y = 7'(y); bus.vga_colour = 3'(c); bus.vga_plot = 1'b1;
      @(posedge clk); #1;
      bus.vga_plot = 1'b0;
      model_plot(x, y, c, 1'b0);
   endtask

   task automatic push_scan();
      for (int i = 0; i < NPIX; i++)
         sb.push_back('{x: i % FB_W, y: i / FB_W, c: fb[i], last: (i == NPIX - 1)});
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_plot_count"}, int'(plot_count), m_plot);
      check({tag, "_drop_count"}, int'(drop_count), m_drop);
   endtask

   // Expectations must already be on the scoreboard; disturb adds mid-scan plots and ignored requests.
   task automatic run_scan(input string tag, input bit disturb);
      int n;
      seen_valid = 0; first_v = -1; last_v = -1;
      @(posedge clk); #1 scan_start = 1'b1;
      @(posedge clk); #1 scan_start = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy || n >= 30000) break;
         n++;
         if (disturb) begin
            if (n == 100) begin
               bus.vga_x = 8'd0; bus.vga_y = 7'd119; bus.vga_colour = 3'b101; bus.vga_plot = 1'b1;
            end else if (n >= 101 && n <= 108) begin
               bus.vga_x = 8'(dx[n-101]); bus.vga_y = 7'(dy[n-101]);
               bus.vga_colour = 3'(dc[n-101]); bus.vga_plot = 1'b1;
            end else begin
               bus.vga_plot = 1'b0;
            end
            scan_start = (n == 200);
            clear_req  = (n == 300);
         end
      end
      @(negedge clk);
      check({tag, "_busy_cycles"}, n, NPIX + 1);
      check({tag, "_valid_count"}, seen_valid, NPIX);
      check({tag, "_valid_span"}, last_v - first_v + 1, NPIX);
      check({tag, "_sb_left"}, sb.size(), 0);
      sb.delete();
   endtask

   always @(negedge clk) begin
      cyc++;
      if (bus.pix_valid) begin
         seen_valid++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL pix_unexpected: got x=%0d y=%0d c=%0d, none expected",
                     bus.pix_x, bus.pix_y, bus.pix_colour);
         end else begin
            exp_p = sb.pop_front();
            if (int'(bus.pix_x) != exp_p.x || int'(bus.pix_y) != exp_p.y ||
                int'(bus.pix_colour) != exp_p.c || bus.pix_last != exp_p.last) begin
               fails++;
               $display("FAIL pixel: got x=%0d y=%0d c=%0d last=%0d expected x=%0d y=%0d c=%0d last=%0d",
                        bus.pix_x, bus.pix_y, bus.pix_colour, bus.pix_last,
                        exp_p.x, exp_p.y, exp_p.c, exp_p.last);
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.vga_plot = 1'b0;
      m_plot = 0; m_drop = 0;
      model_bbox_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_pix_valid", int'(bus.pix_valid), 0);
      check("rst_pix_last", int'(bus.pix_last), 0);
      check("rst_pix_xy", int'({bus.pix_x, bus.pix_y}), 0);
      check("rst_pix_colour", int'(bus.pix_colour), 0);
      check_counts("rst");
      @(posedge clk); #1 rst = 1'b0;

      // Clear sweep with a plot attempt in the middle of it.
      @(posedge clk); #1 clear_req = 1'b1;
      @(posedge clk); #1 clear_req = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy || n >= 30000) break;
         n++;
         if (n == 5000) begin
            bus.vga_x = 8'd10; bus.vga_y = 7'd10; bus.vga_colour = 3'b111; bus.vga_plot = 1'b1;
         end else begin
            bus.vga_plot = 1'b0;
         end
      end
      check("clear_busy_cycles", n, NPIX);
      model_plot(10, 10, 7, 1'b1);
      for (int i = 0; i < NPIX; i++) fb[i] = 0;
      model_bbox_reset();
      check_counts("clear");
`ifdef PLOT_FB_SINK_BBOX_EN
      check("clear_bbox_valid", int'(bbox_valid), 0);
`endif

      push_scan();
      run_scan("scan0", 1'b0);

      do_plot(30, 20, 3'b010);
      check("one_plot_count", int'(plot_count), 1);
      do_plot(110, 100, 3'b110);
      do_plot(70, 60, 3'b001);
`ifdef PLOT_FB_SINK_BBOX_EN
      @(negedge clk);
      check("bbox_valid", int'(bbox_valid), 1);
      check("bbox_xmin", int'(bbox_xmin), 30);
      check("bbox_xmax", int'(bbox_xmax), 110);
      check("bbox_ymin", int'(bbox_ymin), 20);
      check("bbox_ymax", int'(bbox_ymax), 100);
`endif
      do_plot(160, 5, 1);
      do_plot(5, 120, 1);
      do_plot(255, 127, 1);
      @(negedge clk);
      check("bad_drop_count", int'(drop_count), 4);
      check("bad_plot_count", int'(plot_count), 3);

      do_plot(50, 50, 1);
      do_plot(50, 50, 6);
      for (int i = 0; i < 20; i++)
         do_plot($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7));
      @(negedge clk);
      check_counts("rand");
`ifdef PLOT_FB_SINK_BBOX_EN
      check("rand_bbox_xmin", int'(bbox_xmin), bx0);
      check("rand_bbox_xmax", int'(bbox_xmax), bx1);
      check("rand_bbox_ymin", int'(bbox_ymin), by0);
      check("rand_bbox_ymax", int'(bbox_ymax), by1);
`endif

      // Mid-scan plots land in rows the scan has not reached yet.
      model_plot(0, 119, 3'b101, 1'b0);
      for (int i = 0; i < 8; i++) begin
         dx[i] = $urandom_range(0, FB_W - 1);
         dy[i] = $urandom_range(110, 118);
         dc[i] = $urandom_range(0, 7);
         model_plot(dx[i], dy[i], dc[i], 1'b0);
      end
      push_scan();
      run_scan("scan1", 1'b1);
      check_counts("scan1");

      // Reset in the middle of a scan; framebuffer contents must survive.
      push_scan();
      @(posedge clk); #1 scan_start = 1'b1;
      @(posedge clk); #1 scan_start = 1'b0;
      repeat (50) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midscan_rst_busy", int'(busy), 0);
      check("midscan_rst_pix_valid", int'(bus.pix_valid), 0);
      check("midscan_rst_pix_last", int'(bus.pix_last), 0);
      check("midscan_rst_pix_xy", int'({bus.pix_x, bus.pix_y}), 0);
      check("midscan_rst_pix_colour", int'(bus.pix_colour), 0);
      sb.delete();
      m_plot = 0; m_drop = 0;
      model_bbox_reset();
      check_counts("midscan_rst");
      @(posedge clk); #1 rst = 1'b0;

      push_scan();
      run_scan("scan2", 1'b0);

      // Clear entry drops the bounding box; reset then aborts the sweep.
      do_plot(5, 5, 3);
      @(posedge clk); #1 clear_req = 1'b1;
      @(posedge clk); #1 clear_req = 1'b0;
      repeat (10) @(negedge clk);
      check("clear2_busy", int'(busy), 1);
`ifdef PLOT_FB_SINK_BBOX_EN
      check("clear2_bbox_valid", int'(bbox_valid), 0);
`endif
      #2 rst = 1'b1;
      #1;
      check("midclear_rst_busy", int'(busy), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("after_midclear_busy", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
